// File: rtl/ip_packet_pkg.sv
// Framing constants and FSM state type shared by ip_packet_tx and ip_packet_rx.
// IP_PACKET_TX_MIN_FRAME_PAD_EN adds the PAD state for minimum-size frames.
package ip_packet_pkg;

    localparam int unsigned ETH_HDR_SIZE_BYTES  = 14;
    localparam int unsigned IP_HDR_SIZE_BYTES   = 24;
    localparam int unsigned ETH_MIN_FRAME_BYTES = 60;

    localparam logic [15:0]  ETHERTYPE       = 16'h9999;
    localparam logic [127:0] IP_HDR_TEMPLATE = {16{8'h99}};

`ifdef IP_PACKET_TX_MIN_FRAME_PAD_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ETH_HDR,
        ST_IP_HDR,
        ST_PAYLOAD,
        ST_PAD
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ETH_HDR,
        ST_IP_HDR,
        ST_PAYLOAD
    } tx_state_e;
`endif

    function automatic int unsigned pad_bytes(input int unsigned payload_bytes);
        int unsigned frame;
        frame = ETH_HDR_SIZE_BYTES + IP_HDR_SIZE_BYTES + payload_bytes;
        return (frame < ETH_MIN_FRAME_BYTES) ? ETH_MIN_FRAME_BYTES - frame : 0;
    endfunction

endpackage

// File: rtl/ip_packet_tx_byte_serializer.sv
// Picks byte idx_i (LSB byte first) out of a parallel section vector.
// The byte holds as long as idx_i holds, which gives stability under stalls.
module byte_serializer #(
    parameter int unsigned NBYTES = 1,
    parameter int unsigned CW     = 16
) (
    input  logic [NBYTES*8-1:0] vec_i,
    input  logic [CW-1:0]       idx_i,
    input  logic                sel_i,
    output logic [7:0]          byte_o,
    output logic                last_o
);

    logic [NBYTES*8-1:0] shifted;

    assign shifted = vec_i >> {idx_i, 3'b000};
    assign byte_o  = sel_i ? shifted[7:0] : 8'h00;
    assign last_o  = sel_i && (idx_i == CW'(NBYTES - 1));

endmodule

// File: rtl/ip_packet_tx.sv
// Ethernet + IP header + payload framer onto a byte-wide AXI-Stream.
// Define IP_PACKET_TX_MIN_FRAME_PAD_EN to zero-pad short frames to 60 bytes.
module ip_packet_tx #(
    parameter int unsigned IP_ADDR_WIDTH    = 32,
    parameter int unsigned MAC_ADDR_WIDTH   = 48,
    parameter int unsigned AXI_S_DATA_WIDTH = 8,
    parameter int unsigned COUNTER_WIDTH    = 16,
    parameter int unsigned USER_DATA_BYTES  = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [IP_ADDR_WIDTH-1:0]      ACCELERATOR_IP_ADDRESS,
    input  logic [MAC_ADDR_WIDTH-1:0]     ACCELERATOR_MAC_ADDRESS,
    input  logic [IP_ADDR_WIDTH-1:0]      DST_IP_ADDRESS,
    input  logic [MAC_ADDR_WIDTH-1:0]     DST_MAC_ADDRESS,
    input  logic [USER_DATA_BYTES*8-1:0]  RESULT_DATA,
    input  logic                          RESULT_VALID,
    output logic                          RESULT_READY,
    output logic [AXI_S_DATA_WIDTH-1:0]   MAC_DATA_IN,
    output logic                          MAC_DATA_VALID,
    input  logic                          MAC_DATA_READY,
    output logic                          MAC_DATA_LAST,
    output logic                          MAC_DATA_TUSER,
    output logic                          TX_BUSY
);

    import ip_packet_pkg::*;

    localparam int unsigned CW = COUNTER_WIDTH;

    tx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [USER_DATA_BYTES*8-1:0] payload_q;
    logic [IP_ADDR_WIDTH-1:0]     src_ip_q, dst_ip_q;
    logic [MAC_ADDR_WIDTH-1:0]    src_mac_q, dst_mac_q;

    logic [ETH_HDR_SIZE_BYTES*8-1:0] eth_vec;
    logic [IP_HDR_SIZE_BYTES*8-1:0]  ip_vec;

    logic [7:0] eth_byte, ip_byte, pl_byte;
    logic       eth_last, ip_last, pl_last, pad_last;
    logic       accept, hs, sec_last, frame_last;

    assign eth_vec = {ETHERTYPE, src_mac_q, dst_mac_q};
    assign ip_vec  = {dst_ip_q, src_ip_q, IP_HDR_TEMPLATE};

    byte_serializer #(.NBYTES(ETH_HDR_SIZE_BYTES), .CW(CW)) u_eth (
        .vec_i  (eth_vec),
        .idx_i  (cnt_q),
        .sel_i  (state_q == ST_ETH_HDR),
        .byte_o (eth_byte),
        .last_o (eth_last)
    );

    byte_serializer #(.NBYTES(IP_HDR_SIZE_BYTES), .CW(CW)) u_ip (
        .vec_i  (ip_vec),
        .idx_i  (cnt_q),
        .sel_i  (state_q == ST_IP_HDR),
        .byte_o (ip_byte),
        .last_o (ip_last)
    );

    byte_serializer #(.NBYTES(USER_DATA_BYTES), .CW(CW)) u_pl (
        .vec_i  (payload_q),
        .idx_i  (cnt_q),
        .sel_i  (state_q == ST_PAYLOAD),
        .byte_o (pl_byte),
        .last_o (pl_last)
    );

`ifdef IP_PACKET_TX_MIN_FRAME_PAD_EN
    localparam int unsigned PAD_BYTES = pad_bytes(USER_DATA_BYTES);
    localparam bit          HAS_PAD   = (PAD_BYTES != 0);

    assign pad_last   = (state_q == ST_PAD) && (cnt_q == CW'(PAD_BYTES - 1));
    assign frame_last = HAS_PAD ? pad_last : pl_last;
`else
    assign pad_last   = 1'b0;
    assign frame_last = pl_last;
`endif

    assign sec_last = eth_last | ip_last | pl_last | pad_last;

    assign RESULT_READY   = (state_q == ST_IDLE);
    assign TX_BUSY        = (state_q != ST_IDLE);
    assign MAC_DATA_VALID = (state_q != ST_IDLE);
    // Pad bytes are zero, so OR-ing the section bytes covers them too.
    assign MAC_DATA_IN    = eth_byte | ip_byte | pl_byte;
    assign MAC_DATA_LAST  = frame_last;
    assign MAC_DATA_TUSER = 1'b0;

    assign accept = RESULT_READY & RESULT_VALID;
    assign hs     = MAC_DATA_VALID & MAC_DATA_READY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = ST_ETH_HDR;
            cnt_d   = '0;
        end else if (hs) begin
            if (sec_last) begin
                cnt_d = '0;
                unique case (state_q)
                    ST_ETH_HDR: state_d = ST_IP_HDR;
                    ST_IP_HDR:  state_d = ST_PAYLOAD;
`ifdef IP_PACKET_TX_MIN_FRAME_PAD_EN
                    ST_PAYLOAD: state_d = HAS_PAD ? ST_PAD : ST_IDLE;
                    ST_PAD:     state_d = ST_IDLE;
`else
                    ST_PAYLOAD: state_d = ST_IDLE;
`endif
                    default:    state_d = ST_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            payload_q <= '0;
            src_ip_q  <= '0;
            dst_ip_q  <= '0;
            src_mac_q <= '0;
            dst_mac_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                payload_q <= RESULT_DATA;
                src_ip_q  <= ACCELERATOR_IP_ADDRESS;
                dst_ip_q  <= DST_IP_ADDRESS;
                src_mac_q <= ACCELERATOR_MAC_ADDRESS;
                dst_mac_q <= DST_MAC_ADDRESS;
            end
        end
    end

endmodule

// File: tb/tb_ip_packet_tx.sv
// Randomized bench for ip_packet_tx against a byte-queue frame model.
// Build with IP_PACKET_TX_MIN_FRAME_PAD_EN to check the padded variant.
module tb_ip_packet_tx;

    localparam int UDB = 4;
`ifdef IP_PACKET_TX_MIN_FRAME_PAD_EN
    localparam int FRAME_LEN = (38 + UDB < 60) ? 60 : 38 + UDB;
`else
    localparam int FRAME_LEN = 38 + UDB;
`endif

    logic           ACLK = 1'b0;
    logic           ARESET = 1'b0;
    logic [31:0]    ACCELERATOR_IP_ADDRESS = '0;
    logic [47:0]    ACCELERATOR_MAC_ADDRESS = '0;
    logic [31:0]    DST_IP_ADDRESS = '0;
    logic [47:0]    DST_MAC_ADDRESS = '0;
    logic [UDB*8-1:0] RESULT_DATA = '0;
    logic           RESULT_VALID = 1'b0;
    logic           RESULT_READY;
    logic [7:0]     MAC_DATA_IN;
    logic           MAC_DATA_VALID;
    logic           MAC_DATA_READY = 1'b0;
    logic           MAC_DATA_LAST;
    logic           MAC_DATA_TUSER;
    logic           TX_BUSY;

    ip_packet_tx #(
        .IP_ADDR_WIDTH    (32),
        .MAC_ADDR_WIDTH   (48),
        .AXI_S_DATA_WIDTH (8),
        .COUNTER_WIDTH    (16),
        .USER_DATA_BYTES  (UDB)
    ) dut (
        .ACLK                    (ACLK),
        .ARESET                  (ARESET),
        .ACCELERATOR_IP_ADDRESS  (ACCELERATOR_IP_ADDRESS),
        .ACCELERATOR_MAC_ADDRESS (ACCELERATOR_MAC_ADDRESS),
        .DST_IP_ADDRESS          (DST_IP_ADDRESS),
        .DST_MAC_ADDRESS         (DST_MAC_ADDRESS),
        .RESULT_DATA             (RESULT_DATA),
        .RESULT_VALID            (RESULT_VALID),
        .RESULT_READY            (RESULT_READY),
        .MAC_DATA_IN             (MAC_DATA_IN),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .MAC_DATA_TUSER          (MAC_DATA_TUSER),
        .TX_BUSY                 (TX_BUSY)
    );

    always #5 ACLK = ~ACLK;

    logic [7:0] exp_q[$];
    logic [7:0] dut_frame[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_prints = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int byte_idx = 0;
    int last_len = 0;
    int last_pop_cyc = 0;
    bit rnd_ready = 1'b0;
    bit m_idle;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            if (fail_prints < 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
            fail_prints++;
        end
    endtask

    // Expected frame: header fields LSB byte first, then payload, then zero pad.
    task automatic push_frame(input logic [UDB*8-1:0] pl, input logic [31:0] sip,
                              input logic [31:0] dip, input logic [47:0] smac,
                              input logic [47:0] dmac);
        for (int i = 0; i < 6; i++) exp_q.push_back(dmac[i*8 +: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(smac[i*8 +: 8]);
        for (int i = 0; i < 18; i++) exp_q.push_back(8'h99);
        for (int i = 0; i < 4; i++) exp_q.push_back(sip[i*8 +: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(dip[i*8 +: 8]);
        for (int i = 0; i < UDB; i++) exp_q.push_back(pl[i*8 +: 8]);
        while (exp_q.size() < FRAME_LEN) exp_q.push_back(8'h00);
    endtask

    initial begin
        forever begin
            @(negedge ACLK);
            cyc++;
            if (!ARESET) begin
                exp_q.delete();
                chk("rst_valid", MAC_DATA_VALID, 0);
                chk("rst_last", MAC_DATA_LAST, 0);
                chk("rst_data", MAC_DATA_IN, 0);
                chk("rst_busy", TX_BUSY, 0);
                chk("rst_tuser", MAC_DATA_TUSER, 0);
            end else begin
                m_idle = (exp_q.size() == 0);
                chk("valid", MAC_DATA_VALID, !m_idle);
                chk("result_ready", RESULT_READY, m_idle);
                chk("busy", TX_BUSY, !m_idle);
                chk("tuser", MAC_DATA_TUSER, 0);
                if (!m_idle) begin
                    chk("data", MAC_DATA_IN, exp_q[0]);
                    chk("last", MAC_DATA_LAST, exp_q.size() == 1);
                    if (MAC_DATA_READY) begin
                        dut_frame.push_back(MAC_DATA_IN);
                        void'(exp_q.pop_front());
                        byte_idx++;
                        if (exp_q.size() == 0) begin
                            last_len = byte_idx;
                            last_pop_cyc = cyc;
                        end
                    end
                end
                if (m_idle && RESULT_VALID) begin
                    push_frame(RESULT_DATA, ACCELERATOR_IP_ADDRESS, DST_IP_ADDRESS,
                               ACCELERATOR_MAC_ADDRESS, DST_MAC_ADDRESS);
                    acc_cnt++;
                    acc_cyc = cyc;
                    byte_idx = 0;
                    dut_frame.delete();
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge ACLK);
            #2;
            if (rnd_ready) MAC_DATA_READY = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic send(input logic [UDB*8-1:0] pl, input logic [31:0] sip,
                        input logic [31:0] dip, input logic [47:0] smac,
                        input logic [47:0] dmac, input bit hold);
        int a0;
        a0 = acc_cnt;
        RESULT_DATA = pl;
        ACCELERATOR_IP_ADDRESS = sip;
        DST_IP_ADDRESS = dip;
        ACCELERATOR_MAC_ADDRESS = smac;
        DST_MAC_ADDRESS = dmac;
        RESULT_VALID = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (acc_cnt != a0) break;
        end
        chk("accept_timeout", acc_cnt != a0, 1);
        if (!hold) RESULT_VALID = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
        chk("frame_timeout", exp_q.size() == 0, 1);
        tick();
    endtask

    task automatic send_random(input bit hold);
        send(UDB*8'($urandom), $urandom, $urandom,
             {16'($urandom), $urandom}, {16'($urandom), $urandom}, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        ARESET = 1'b1;
        tick();

        // Happy path with literal expectations
        MAC_DATA_READY = 1'b1;
        send(32'h04030201, 32'hcccccccc, 32'hbbaaaaaa,
             48'h112233445566, 48'hccffffffffff, 1'b0);
        wait_done();
        chk("hp_len", last_len, FRAME_LEN);
        chk("hp_b0", dut_frame[0], 8'hff);
        chk("hp_b5", dut_frame[5], 8'hcc);
        chk("hp_b6", dut_frame[6], 8'h66);
        chk("hp_b11", dut_frame[11], 8'h11);
        chk("hp_b12", dut_frame[12], 8'h99);
        chk("hp_b14", dut_frame[14], 8'h99);
        chk("hp_b30", dut_frame[30], 8'hcc);
        chk("hp_b34", dut_frame[34], 8'haa);
        chk("hp_b37", dut_frame[37], 8'hbb);
        chk("hp_b38", dut_frame[38], 8'h01);
        chk("hp_b41", dut_frame[41], 8'h04);
`ifdef IP_PACKET_TX_MIN_FRAME_PAD_EN
        chk("hp_b42", dut_frame[42], 8'h00);
        chk("hp_b59", dut_frame[59], 8'h00);
`endif

        // Random backpressure
        rnd_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            send_random(1'b0);
            wait_done();
            chk("bp_len", last_len, FRAME_LEN);
        end
        rnd_ready = 1'b0;
        MAC_DATA_READY = 1'b1;
        tick();

        // Back-to-back, inputs changed mid-frame
        send(32'hdeadbeef, 32'h0a000001, 32'h0a000002,
             48'h0000aaaaaaaa, 48'h0000bbbbbb01, 1'b1);
        send(32'h87654321, 32'h0b000001, 32'h0b000002,
             48'h0000cccccccc, 48'h0000dddddd02, 1'b0);
        chk("b2b_gap", acc_cyc - last_pop_cyc, 1);
        wait_done();
        chk("b2b_len", last_len, FRAME_LEN);
        chk("b2b_b0", dut_frame[0], 8'h02);
        chk("b2b_b38", dut_frame[38], 8'h21);

        // Reset inside the IP header
        send_random(1'b0);
        for (int i = 0; i < 300 && byte_idx < 20; i++) tick();
        chk("rst_reach_b20", byte_idx, 20);
        ARESET = 1'b0;
        tick();
        tick();
        ARESET = 1'b1;
        tick();
        send(32'h44332211, 32'h01020304, 32'h05060708,
             48'h0a0b0c0d0e0f, 48'h101112131415, 1'b0);
        wait_done();
        chk("post_rst_len", last_len, FRAME_LEN);
        chk("post_rst_b0", dut_frame[0], 8'h15);
        chk("post_rst_b41", dut_frame[41], 8'h44);

        // A few more random frames under backpressure
        rnd_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            send_random(1'b0);
            wait_done();
        end
        rnd_ready = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
